// File: rtl/mips_data_mem_responder_pkg.sv
// Shared definitions for the MIPS data-memory responder: defaults, FSM encoding,
// debug view and the address-fault decode.
package mips_mem_pkg;

    localparam int          DATA_WIDTH_DEF = 32;
    localparam int          ADDR_WIDTH_DEF = 8;
    localparam logic [31:0] BASE_ADDR_DEF  = 32'h1001_0000;
    localparam int          WAIT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        state_t                    state;
        logic [WAIT_CNT_WIDTH-1:0] wait_count;
    } dbg_t;

    // The subtraction is widened by one bit so an address below the base shows
    // up as a borrow instead of wrapping onto a legal word.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [32:0] span);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return off[32] || (off >= span) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// Request/response bus between the multicycle core (master) and the data memory (slave).
// Handshake: a request is taken on a rising edge where req_valid && req_ready; the
// master holds its request until then. rsp_valid is a one-cycle pulse, no back-pressure.
interface mips_data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  req_valid;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/mips_data_mem_responder_wait_state_counter.sv
// Up-counter with enable, synchronous clear and a terminal flag raised when the
// count reaches LIMIT-1 (LIMIT cycles of enable from a cleared start).
module wait_state_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TC_VAL = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for the multicycle MIPS core: accepts one word access,
// spends WAIT_STATES cycles in WAIT, then commits the store or returns the load.
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int          ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          WAIT_STATES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_data_mem_responder_if.slave    bus,
    output dbg_t                        dbg
);

    localparam int          DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    state_t                    state;
    state_t                    state_nx;
    logic                      lat_we;
    logic [31:0]               lat_addr;
    logic [DATA_WIDTH-1:0]     lat_wdata;
    logic                      acc_we;
    logic [31:0]               acc_addr;
    logic [DATA_WIDTH-1:0]     acc_wdata;
    logic                      fault;
    logic [ADDR_WIDTH-1:0]     idx;
    logic                      accept;
    logic                      commit;
    logic [WAIT_CNT_WIDTH-1:0] wait_count;
    logic                      wait_tc;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;
    logic                      rsp_err_q;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    wait_state_counter #(
        .WIDTH (WAIT_CNT_WIDTH),
        .LIMIT (WAIT_STATES)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_WAIT),
        .clr   ((state != ST_WAIT) || wait_tc),
        .count (wait_count),
        .tc    (wait_tc)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.req_valid) state_nx = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (wait_tc) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign accept = (state == ST_IDLE) && bus.req_valid;
    assign commit = (state_nx == ST_RESP) && (state != ST_RESP);

    // With no wait states the access commits on the accepting edge, before the
    // latches hold the request, so decode straight off the bus while IDLE.
    assign acc_we    = (state == ST_IDLE) ? bus.req_we    : lat_we;
    assign acc_addr  = (state == ST_IDLE) ? bus.req_addr  : lat_addr;
    assign acc_wdata = (state == ST_IDLE) ? bus.req_wdata : lat_wdata;

    assign fault = addr_fault(acc_addr, BASE_ADDR, SPAN);
    assign idx   = ADDR_WIDTH'((acc_addr - BASE_ADDR) >> 2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
            if (commit) begin
                rsp_err_q   <= fault;
                rsp_rdata_q <= (fault || acc_we) ? '0 : mem[idx];
            end
        end
    end

    // Array has no reset; a write is never allowed while reset is held.
    always_ff @(posedge clk) begin
        if (reset && commit && acc_we && !fault) begin
            mem[idx] <= acc_wdata;
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign dbg.state      = state;
    assign dbg.wait_count = wait_count;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Bench for mips_data_mem_responder: a 2-wait-state and a 0-wait-state instance
// checked against an address-level memory model.
module tb_mips_data_mem_responder;
  import mips_mem_pkg::*;

  localparam int          DW   = 32;
  localparam int          AW   = 8;
  localparam int          WS0  = 2;
  localparam int          WS1  = 0;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  logic reset;
  dbg_t dbg0;
  dbg_t dbg1;

  always #5 clk = ~clk;

  mips_data_mem_responder_if #(.DATA_WIDTH(DW)) if0 ();
  mips_data_mem_responder_if #(.DATA_WIDTH(DW)) if1 ();

  mips_data_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(WS0))
    dut0 (.clk(clk), .reset(reset), .bus(if0), .dbg(dbg0));
  mips_data_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(WS1))
    dut1 (.clk(clk), .reset(reset), .bus(if1), .dbg(dbg1));

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic bit model_fault(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off < 0) || (off >= 4 * (2 ** AW)) || (off % 4 != 0);
  endfunction

  function automatic int model_key(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic void model_access(input bit we, input logic [31:0] a, input logic [DW-1:0] wd,
                                       output logic [DW-1:0] rd, output bit err);
    err = model_fault(a);
    rd  = '0;
    if (!err) begin
      if (we) model_mem[model_key(a)] = wd;
      else rd = model_mem.exists(model_key(a)) ? model_mem[model_key(a)] : 'x;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue0(input bit we, input logic [31:0] a, input logic [DW-1:0] wd,
                        output int lat, output logic [DW-1:0] rd, output logic err,
                        output bit hs_ok, output bit idle_ok);
    int n;
    lat = -1; rd = '0; err = 1'b0; hs_ok = 1'b1; idle_ok = 1'b0;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_we = we; if0.req_addr = a; if0.req_wdata = wd;
    n = 0;
    while (if0.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    for (int c = 1; c <= WS0 + 4 && lat < 0; c++) begin
      @(negedge clk);
      if (if0.req_ready !== 1'b0 || if0.busy !== 1'b1) hs_ok = 1'b0;
      if (if0.rsp_valid === 1'b1) begin lat = c; rd = if0.rsp_rdata; err = if0.rsp_err; end
    end
    if (lat >= 0) begin
      @(negedge clk);
      idle_ok = (if0.rsp_valid === 1'b0) && (if0.req_ready === 1'b1) && (if0.busy === 1'b0)
                && (if0.rsp_rdata === rd) && (if0.rsp_err === err);
    end
  endtask

  task automatic issue1(input bit we, input logic [31:0] a, input logic [DW-1:0] wd,
                        output int lat, output logic [DW-1:0] rd, output logic err);
    int n;
    lat = -1; rd = '0; err = 1'b0;
    @(negedge clk);
    if1.req_valid = 1'b1; if1.req_we = we; if1.req_addr = a; if1.req_wdata = wd;
    n = 0;
    while (if1.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    for (int c = 1; c <= WS1 + 4 && lat < 0; c++) begin
      @(negedge clk);
      if (if1.rsp_valid === 1'b1) begin lat = c; rd = if1.rsp_rdata; err = if1.rsp_err; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = '0; if1.req_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (if0.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", if0.req_ready); end
    tests_run++; if (if0.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", if0.rsp_valid); end
    tests_run++; if (if0.rsp_rdata !== '0 || if0.rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h/%b expected 0/0", if0.rsp_rdata, if0.rsp_err); end
    tests_run++; if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", if0.busy); end
    tests_run++; if (dbg0.state !== ST_IDLE || dbg0.wait_count !== '0) begin tests_failed++; $display("FAIL reset_dbg: got %0d/%0d expected 0/0", dbg0.state, dbg0.wait_count); end
    tests_run++; if (if1.req_ready !== 1'b1 || if1.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dut1: got %b/%b expected 1/0", if1.req_ready, if1.rsp_valid); end
  endtask

  task automatic test_store_load();
    bit            ow  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0]   oa  [4] = '{32'h1001_0000, 32'h1001_0000, 32'h1001_0004, 32'h1001_0004};
    logic [DW-1:0] od  [4] = '{32'h0000_002C, 32'h0, 32'd20, 32'h0};
    logic [DW-1:0] exp_d, rd;
    bit exp_e, hs, idl;
    logic err;
    int lat;
    for (int i = 0; i < 4; i++) begin
      model_access(ow[i], oa[i], od[i], exp_d, exp_e);
      issue0(ow[i], oa[i], od[i], lat, rd, err, hs, idl);
      tests_run++; if (lat != WS0 + 1) begin tests_failed++; $display("FAIL sl%0d_latency: got %0d expected %0d", i, lat, WS0 + 1); end
      tests_run++; if (rd !== exp_d || err !== exp_e) begin tests_failed++; $display("FAIL sl%0d_rsp: got %h/%b expected %h/%b", i, rd, err, exp_d, exp_e); end
      tests_run++; if (!hs || !idl) begin tests_failed++; $display("FAIL sl%0d_handshake: got %b/%b expected 1/1", i, hs, idl); end
    end
  endtask

  task automatic test_faults();
    bit          ow [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] oa [7] = '{32'h1001_0002, 32'h1000_FFFC, 32'h1001_0400, 32'hFFFF_FFFC,
                            32'h1001_03FC, 32'h1001_03FC, 32'h1001_0000};
    logic [DW-1:0] exp_d, rd, wd;
    bit exp_e, hs, idl;
    logic err;
    int lat;
    for (int i = 0; i < 7; i++) begin
      wd = $urandom();
      model_access(ow[i], oa[i], wd, exp_d, exp_e);
      issue0(ow[i], oa[i], wd, lat, rd, err, hs, idl);
      tests_run++; if (lat != WS0 + 1) begin tests_failed++; $display("FAIL flt%0d_latency: got %0d expected %0d", i, lat, WS0 + 1); end
      tests_run++; if (rd !== exp_d || err !== exp_e) begin tests_failed++; $display("FAIL flt%0d_rsp @%h: got %h/%b expected %h/%b", i, oa[i], rd, err, exp_d, exp_e); end
      tests_run++; if (!idl) begin tests_failed++; $display("FAIL flt%0d_hold: got %b expected 1", i, idl); end
    end
  endtask

  task automatic test_random();
    int written[$];
    logic [31:0] a;
    logic [DW-1:0] exp_d, rd, wd;
    bit exp_e, hs, idl, we;
    logic err;
    int lat, kind;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      wd = $urandom();
      we = 1'b1;
      if (kind == 1 && written.size() == 0) kind = 0;
      case (kind)
        0: begin a = BASE + 4 * $urandom_range(0, 255); written.push_back(model_key(a)); end
        1: begin a = BASE + 4 * written[$urandom_range(0, written.size() - 1)]; we = 1'b0; end
        2: begin a = BASE - 4 * $urandom_range(1, 4000); we = $urandom_range(0, 1); end
        default: begin
          a = (BASE + 4 * $urandom_range(0, 255)) | 32'($urandom_range(1, 3));
          if ($urandom_range(0, 1) == 1) a = BASE + 1024 + 4 * $urandom_range(0, 4000);
          we = $urandom_range(0, 1);
        end
      endcase
      model_access(we, a, wd, exp_d, exp_e);
      issue0(we, a, wd, lat, rd, err, hs, idl);
      tests_run++; if (lat != WS0 + 1 || !hs || !idl) begin tests_failed++; $display("FAIL rnd%0d_timing: got lat %0d hs %b idle %b expected %0d/1/1", i, lat, hs, idl, WS0 + 1); end
      tests_run++; if (rd !== exp_d || err !== exp_e) begin tests_failed++; $display("FAIL rnd%0d_rsp we=%b @%h: got %h/%b expected %h/%b", i, we, a, rd, err, exp_d, exp_e); end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic [31:0]   ia [N];
    logic [DW-1:0] id [N];
    bit            iw [N];
    logic [DW-1:0] exp_d, got_d;
    bit exp_e;
    int i, last, nrsp;
    for (int j = 0; j < N; j += 2) begin
      ia[j] = BASE + 4 * $urandom_range(0, 255); ia[j+1] = ia[j];
      id[j] = $urandom(); id[j+1] = '0;
      iw[j] = 1'b1; iw[j+1] = 1'b0;
    end
    i = 0; last = -1; nrsp = 0;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_we = iw[0]; if0.req_addr = ia[0]; if0.req_wdata = id[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (if0.rsp_valid === 1'b1) begin
        nrsp++;
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++; $display("FAIL b2b_extra_rsp: got rsp %0d expected none", nrsp);
        end else begin
          got_d = exp_q.pop_front();
          tests_run++; if (if0.rsp_rdata !== got_d || if0.rsp_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_rsp%0d: got %h/%b expected %h/0", nrsp, if0.rsp_rdata, if0.rsp_err, got_d); end
        end
      end
      if (if0.req_ready === 1'b1 && i < N) begin
        if (last >= 0) begin
          tests_run++; if (cyc - last != WS0 + 2) begin tests_failed++; $display("FAIL b2b_interval%0d: got %0d expected %0d", i, cyc - last, WS0 + 2); end
        end
        last = cyc;
        model_access(iw[i], ia[i], id[i], exp_d, exp_e);
        exp_q.push_back(exp_d);
        i++;
        @(posedge clk); #1;
        if (i < N) begin if0.req_we = iw[i]; if0.req_addr = ia[i]; if0.req_wdata = id[i]; end
        else if0.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    if0.req_valid = 1'b0;
    tests_run++; if (i != N || nrsp != N || exp_q.size() != 0) begin tests_failed++; $display("FAIL b2b_count: got acc %0d rsp %0d left %0d expected %0d/%0d/0", i, nrsp, exp_q.size(), N, N); end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] exp_d, rd;
    bit exp_e, hs, idl, seen;
    logic err;
    int lat;
    model_access(1'b1, 32'h1001_0008, 32'h0, exp_d, exp_e);
    issue0(1'b1, 32'h1001_0008, 32'h0, lat, rd, err, hs, idl);
    tests_run++; if (lat != WS0 + 1 || err !== 1'b0) begin tests_failed++; $display("FAIL abort_pre: got %0d/%b expected %0d/0", lat, err, WS0 + 1); end
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_addr = 32'h1001_0008; if0.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (dbg0.state !== ST_WAIT) begin tests_failed++; $display("FAIL abort_in_wait: got %0d expected %0d", dbg0.state, ST_WAIT); end
    reset = 1'b0;
    #1;
    tests_run++; if (if0.req_ready !== 1'b1 || if0.busy !== 1'b0 || if0.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_async: got rdy %b busy %b rsp %b expected 1/0/0", if0.req_ready, if0.busy, if0.rsp_valid); end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (if0.rsp_valid !== 1'b0) seen = 1'b1; end
    reset = 1'b1;
    repeat (4) begin @(negedge clk); if (if0.rsp_valid !== 1'b0) seen = 1'b1; end
    tests_run++; if (seen) begin tests_failed++; $display("FAIL abort_no_rsp: got 1 expected 0"); end
    model_access(1'b1, 32'h1001_000C, 32'h0, exp_d, exp_e);
    issue0(1'b1, 32'h1001_000C, 32'h0, lat, rd, err, hs, idl);
    model_access(1'b0, 32'h1001_0008, 32'h0, exp_d, exp_e);
    issue0(1'b0, 32'h1001_0008, 32'h0, lat, rd, err, hs, idl);
    tests_run++; if (rd !== exp_d || err !== exp_e || lat != WS0 + 1) begin tests_failed++; $display("FAIL abort_dropped: got %h/%b lat %0d expected %h/%b lat %0d", rd, err, lat, exp_d, exp_e, WS0 + 1); end
  endtask

  task automatic test_zero_wait();
    logic [31:0]   a [3];
    logic [DW-1:0] d [3];
    logic [DW-1:0] rd;
    logic err;
    int lat;
    for (int j = 0; j < 3; j++) begin a[j] = BASE + 4 * (j * 37 + 5); d[j] = $urandom(); end
    for (int j = 0; j < 3; j++) begin
      issue1(1'b1, a[j], d[j], lat, rd, err);
      tests_run++; if (lat != WS1 + 1 || rd !== '0 || err !== 1'b0) begin tests_failed++; $display("FAIL zw_sw%0d: got lat %0d %h/%b expected %0d 0/0", j, lat, rd, err, WS1 + 1); end
    end
    for (int j = 2; j >= 0; j--) begin
      issue1(1'b0, a[j], '0, lat, rd, err);
      tests_run++; if (lat != WS1 + 1 || rd !== d[j] || err !== 1'b0) begin tests_failed++; $display("FAIL zw_lw%0d: got lat %0d %h/%b expected %0d %h/0", j, lat, rd, err, WS1 + 1, d[j]); end
    end
    issue1(1'b0, 32'h1001_0401, '0, lat, rd, err);
    tests_run++; if (lat != WS1 + 1 || rd !== '0 || err !== model_fault(32'h1001_0401)) begin tests_failed++; $display("FAIL zw_fault: got lat %0d %h/%b expected %0d 0/1", lat, rd, err, WS1 + 1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_faults();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
